// File: rtl/booth_div_pkg.sv
// Shared types for the sequential signed divider: FSM state encoding and counter sizing.
// No logic; no latency or flow-control behaviour of its own.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_W = 4;

    // Iteration counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nonrestoring_div_step.sv
// One non-restoring division step on magnitudes: shift {acc,qm} left, then add or subtract the divisor.
// Purely combinational; zero latency, no flow control.
module nonrestoring_div_step
    import booth_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   acc,
    input  logic [W-1:0] qm,
    input  logic [W-1:0] divisor,
    output logic [W:0]   acc_next,
    output logic [W-1:0] qm_next
);

    logic [W:0] acc_sh;

    always_comb begin
        acc_sh = {acc[W-1:0], qm[W-1]};
        // The pre-shift sign of the partial remainder picks subtract vs add.
        if (acc[W]) begin
            acc_next = acc_sh + {1'b0, divisor};
        end else begin
            acc_next = acc_sh - {1'b0, divisor};
        end
        qm_next = {qm[W-2:0], ~acc_next[W]};
    end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider (truncating toward zero), one quotient bit per clock on operand magnitudes.
// Latency W+1 cycles from accepted load to done (1 cycle for divide-by-zero); load ignored while busy, no queueing.
module booth_seq_divider
    import booth_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] N,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    localparam int CNT_W = cnt_width(W);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [W:0]         acc;
    logic [W-1:0]       qm;
    logic [W-1:0]       mag_d;
    logic               sign_n;
    logic               sign_d;
    logic               ovf_pend;

    logic [W:0]         acc_next;
    logic [W-1:0]       qm_next;
    logic [W-1:0]       mag_n_in;
    logic [W-1:0]       mag_d_in;
    logic               ovf_in;
    logic [W-1:0]       r_mag;
    logic [W-1:0]       q_fix;
    logic [W-1:0]       r_fix;

    nonrestoring_div_step #(.W(W)) u_step (
        .acc      (acc),
        .qm       (qm),
        .divisor  (mag_d),
        .acc_next (acc_next),
        .qm_next  (qm_next)
    );

    always_comb begin
        // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
        mag_n_in = N[W-1] ? -N : N;
        mag_d_in = D[W-1] ? -D : D;
        ovf_in   = (N == {1'b1, {(W-1){1'b0}}}) && (D == '1);
        r_mag    = acc[W] ? (acc[W-1:0] + mag_d) : acc[W-1:0];
        q_fix    = (sign_n ^ sign_d) ? -qm : qm;
        r_fix    = sign_n ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            qm       <= '0;
            mag_d    <= '0;
            sign_n   <= 1'b0;
            sign_d   <= 1'b0;
            ovf_pend <= 1'b0;
            Q        <= '0;
            R        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (D == '0) begin
                            Q    <= '1;
                            R    <= N;
                            dbz  <= 1'b1;
                            ovf  <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            qm       <= mag_n_in;
                            mag_d    <= mag_d_in;
                            sign_n   <= N[W-1];
                            sign_d   <= D[W-1];
                            ovf_pend <= ovf_in;
                            acc      <= '0;
                            count    <= CNT_W'(W);
                            busy     <= 1'b1;
                            state    <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc   <= acc_next;
                    qm    <= qm_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Q     <= q_fix;
                    R     <= r_fix;
                    ovf   <= ovf_pend;
                    dbz   <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for the W=4 signed divider: reset, signs, overflow, divide-by-zero,
// mid-operation reset, load-while-busy, and a full 256-pair sweep against integer division.
module tb_booth_seq_divider;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] n_drv;
    logic [3:0] d_drv;
    logic [3:0] q_obs;
    logic [3:0] r_obs;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;

    int errors;
    int checks;
    int lat;
    int seen_done;
    int ni, di, eq, er, elat;
    logic edbz, eovf;
    logic signed [3:0] ns, ds;

    booth_seq_divider #(.W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .N     (n_drv),
        .D     (d_drv),
        .Q     (q_obs),
        .R     (r_obs),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one load, then wait (bounded) for done and check latency, busy, result and flags.
    task automatic run_op(input string tag, input logic [3:0] n, input logic [3:0] d,
                          input logic [3:0] exp_q, input logic [3:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf, input int exp_lat);
        int k;
        n_drv = n;
        d_drv = d;
        load  = 1'b1;
        step();
        load = 1'b0;
        check({tag, ".busy"}, {31'd0, busy}, (exp_lat != 0) ? 32'd1 : 32'd0);
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        check({tag, ".lat"}, k, exp_lat);
        check({tag, ".res"}, {22'd0, q_obs, r_obs, dbz, ovf}, {22'd0, exp_q, exp_r, exp_dbz, exp_ovf});
        check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        step();
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        load   = 1'b0;
        n_drv  = '0;
        d_drv  = '0;
        step();
        step();
        reset = 1'b0;
        check("rst.q", {28'd0, q_obs}, 32'd0);
        check("rst.r", {28'd0, r_obs}, 32'd0);
        check("rst.flags", {28'd0, busy, done, dbz, ovf}, 32'd0);

        // Basic quotient/remainder with all sign combinations
        run_op("pos",    4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 5);
        run_op("negn",   4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 5);
        run_op("negd",   4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 5);
        run_op("ovf",    4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 5);
        run_op("minby1", 4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 5);
        run_op("dbz",    4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0, 0);
        run_op("clrdbz", 4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 5);

        // Reset during the second ITER cycle aborts with no done pulse
        n_drv = 4'b0110;
        d_drv = 4'b0011;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.outs", {20'd0, q_obs, r_obs, busy, done, dbz, ovf}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) seen_done++;
        end
        check("abort.nodone", seen_done, 0);
        run_op("after_abort", 4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 5);

        // A load presented while busy must be dropped
        n_drv = 4'b0111;
        d_drv = 4'b0010;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        n_drv = 4'b0001;
        d_drv = 4'b0001;
        load  = 1'b1;
        step();
        load = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("busyload.lat", lat, 5);
        check("busyload.res", {24'd0, q_obs, r_obs}, {24'd0, 4'b0011, 4'b0001});
        step();
        check("busyload.idle", {30'd0, busy, done}, 32'd0);

        // Exhaustive sweep against truncating integer division
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ns = 4'(i);
                ds = 4'(j);
                ni = ns;
                di = ds;
                if (di == 0) begin
                    eq = -1; er = ni; edbz = 1'b1; eovf = 1'b0; elat = 0;
                end else if (ni == -8 && di == -1) begin
                    eq = -8; er = 0; edbz = 1'b0; eovf = 1'b1; elat = 5;
                end else begin
                    eq = ni / di; er = ni % di; edbz = 1'b0; eovf = 1'b0; elat = 5;
                end
                run_op($sformatf("sweep_%0d_%0d", ni, di), ns, ds, eq[3:0], er[3:0], edbz, eovf, elat);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
